// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch widths, PC step and the {pc, inst} queue entry type
package cpu_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int INST_WIDTH = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer of fetch entries with push, pop and flush
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    rd_d = flush ? '0 : rd_q + PW'(pop);
    wr_d = flush ? '0 : wr_q + PW'(push);
    cnt_d = flush ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: PC-driven ROM fetch into a redirectable decode queue; FETCH_HALT_EN adds halt on zero word
module fetch_buffer #(
  parameter int                    ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int                    INST_WIDTH = cpu_pkg::INST_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc
`ifdef FETCH_HALT_EN
  ,
  output logic                  halted
`endif
);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic push, pop, full, empty;
  cpu_pkg::fetch_entry_t head, din;
  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign pop = out_valid & out_ready;
  assign out_inst = empty ? '0 : head.inst;
  assign out_pc = empty ? '0 : head.pc;
  assign din = '{pc: imem_addr, inst: imem_data};
`ifdef FETCH_HALT_EN
  logic halted_q, halted_d, slot;
  assign slot = !redirect_valid & (!full | pop) & !halted_q;
  assign push = slot & (imem_data != '0);
  assign halted = halted_q;
  always_comb halted_d = redirect_valid ? 1'b0 : (halted_q | (slot & (imem_data == '0)));
  always_ff @(posedge clk) halted_q <= !rst_n ? 1'b0 : halted_d;
`else
  assign push = !redirect_valid & (!full | pop);
`endif
  always_comb pc_d = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00}
                   : push ? pc_q + ADDR_WIDTH'(cpu_pkg::PC_STEP) : pc_q;
  always_ff @(posedge clk) pc_q <= !rst_n ? RESET_PC : pc_d;
  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of fetch, stall, redirect, PC wrap and optional halt
module tb_fetch_buffer;
  logic clk = 0, rst_n = 0, redirect_valid = 0, out_ready = 0, out_valid, zero_c = 0;
  logic [11:0] imem_addr, redirect_pc = '0, out_pc;
  logic [31:0] imem_data, out_inst;
  int n_chk = 0, n_err = 0;
`ifdef FETCH_HALT_EN
  logic halted;
`endif
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [11:0] a, input logic z);
    return (z && a == 12'h00C) ? 32'h0 : 32'h11111111 * (32'(a[11:2]) + 32'd1);
  endfunction
  assign imem_data = rom(imem_addr, zero_c);
  fetch_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc)
`ifdef FETCH_HALT_EN
    ,
    .halted(halted)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset(input logic rdy);
    rst_n = 0;
    redirect_valid = 0;
    out_ready = rdy;
    tick();
    tick();
    rst_n = 1;
  endtask
  initial begin
    do_reset(1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flow_valid", 64'(out_valid), 64'd1);
      chk("flow_pc", 64'(out_pc), 64'(4 * i));
      chk("flow_inst", 64'(out_inst), 64'(32'h11111111 * (i + 1)));
    end
    do_reset(0);
    repeat (10) tick();
    chk("stall_addr", 64'(imem_addr), 64'h010);
    chk("stall_pc", 64'(out_pc), 64'h000);
    chk("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc", 64'(out_pc), 64'(4 * i));
      chk("drain_inst", 64'(out_inst), 64'(32'h11111111 * (i + 1)));
      chk("drain_addr", 64'(imem_addr), 64'(16 + 4 * i));
      tick();
    end
    do_reset(0);
    repeat (3) tick();
    chk("pre_redir_addr", 64'(imem_addr), 64'h00C);
    redirect_valid = 1;
    redirect_pc = 12'h102;
    out_ready = 1;
    tick();
    redirect_valid = 0;
    out_ready = 0;
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'h100);
    chk("redir_pc0", 64'(out_pc), 64'h000);
    tick();
    chk("redir_valid2", 64'(out_valid), 64'd1);
    chk("redir_pc", 64'(out_pc), 64'h100);
    chk("redir_inst", 64'(out_inst), 64'(rom(12'h100, 1'b0)));
    redirect_valid = 1;
    redirect_pc = 12'h200;
    tick();
    redirect_pc = 12'h304;
    tick();
    redirect_valid = 0;
    chk("b2b_addr", 64'(imem_addr), 64'h304);
    chk("b2b_valid", 64'(out_valid), 64'd0);
    tick();
    chk("b2b_pc", 64'(out_pc), 64'h304);
    redirect_valid = 1;
    redirect_pc = 12'hFF8;
    tick();
    redirect_valid = 0;
    out_ready = 1;
    tick();
    chk("wrap_pc0", 64'(out_pc), 64'hFF8);
    tick();
    chk("wrap_pc1", 64'(out_pc), 64'hFFC);
    tick();
    chk("wrap_pc2", 64'(out_pc), 64'h000);
    chk("wrap_inst", 64'(out_inst), 64'h11111111);
    chk("wrap_addr", 64'(imem_addr), 64'h004);
    zero_c = 1;
    do_reset(1);
`ifdef FETCH_HALT_EN
    chk("halt_rst", 64'(halted), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_pc", 64'(out_pc), 64'(4 * i));
    end
    tick();
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_valid", 64'(out_valid), 64'd0);
    chk("halt_addr", 64'(imem_addr), 64'h00C);
    repeat (3) tick();
    chk("halt_hold_addr", 64'(imem_addr), 64'h00C);
    chk("halt_hold", 64'(halted), 64'd1);
    redirect_valid = 1;
    redirect_pc = 12'h000;
    tick();
    redirect_valid = 0;
    chk("halt_clr", 64'(halted), 64'd0);
    chk("halt_clr_addr", 64'(imem_addr), 64'h000);
    tick();
    chk("halt_resume_valid", 64'(out_valid), 64'd1);
    chk("halt_resume_pc", 64'(out_pc), 64'h000);
`else
    repeat (4) tick();
    chk("zero_valid", 64'(out_valid), 64'd1);
    chk("zero_pc", 64'(out_pc), 64'h00C);
    chk("zero_inst", 64'(out_inst), 64'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
